// File: rtl/max7219_pkg.sv
// Shared constants for the MAX7219 receive-side model: register map and frame size.
package max7219_pkg;
  localparam logic [3:0] ADDR_NOOP      = 4'h0;
  localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
  localparam logic [3:0] ADDR_DIGIT1    = 4'h2;
  localparam logic [3:0] ADDR_DIGIT2    = 4'h3;
  localparam logic [3:0] ADDR_DIGIT3    = 4'h4;
  localparam logic [3:0] ADDR_DIGIT4    = 4'h5;
  localparam logic [3:0] ADDR_DIGIT5    = 4'h6;
  localparam logic [3:0] ADDR_DIGIT6    = 4'h7;
  localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
  localparam logic [3:0] ADDR_DECODE    = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY = 4'hA;
  localparam logic [3:0] ADDR_SCANLIM   = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
  localparam logic [3:0] ADDR_TEST      = 4'hF;

  localparam int FRAME_BITS = 16;

  function automatic logic is_digit(input logic [3:0] a);
    return (a >= ADDR_DIGIT0) && (a <= ADDR_DIGIT7);
  endfunction
endpackage

// File: rtl/max7219_serial_receiver_sync_edge.sv
// Multi-flop synchroniser with registered rise/fall pulses; level_o is aligned with the pulses.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic              dly_q;
  logic              rise_q;
  logic              fall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      dly_q  <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~dly_q;
      fall_q <= ~sync_q[STAGES-1] & dly_q;
    end
  end

  assign level_o = dly_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
endmodule

// File: rtl/max7219_serial_receiver.sv
// MAX7219 serial receiver: deserialises 16-bit frames from SCK/DIN/LOAD and keeps the register file.
module max7219_serial_receiver
  import max7219_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sck_in,
  input  logic       din,
  input  logic       load,
  output logic       frame_valid,
  output logic [3:0] frame_addr,
  output logic [7:0] frame_data,
  output logic       frame_err,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       shutdown_n,
  output logic       display_test,
  output logic [3:0] intensity,
  output logic [2:0] scan_limit,
  output logic [7:0] decode_mode
);
  localparam logic [4:0] FRAME_BITS_C = 5'(FRAME_BITS);
  localparam logic [4:0] BITCNT_MAX   = 5'd31;

  logic sck_rise, sck_fall, sck_s;
  logic load_rise, load_fall, load_s;
  logic din_s;

  // sck_fall and sck_s are only needed for alignment; the shifter acts on rises.
  sync_edge #(.STAGES(SYNC_STAGES)) u_sck (
    .clk(clk), .rst_n(rst_n), .d_i(sck_in),
    .level_o(sck_s), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_load (
    .clk(clk), .rst_n(rst_n), .d_i(load),
    .level_o(load_s), .rise_o(load_rise), .fall_o(load_fall)
  );

  // One extra flop so din lines up with the registered edge pulses.
  logic [SYNC_STAGES:0] din_sync_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) din_sync_q <= '0;
    else        din_sync_q <= {din_sync_q[SYNC_STAGES-1:0], din};
  end
  assign din_s = din_sync_q[SYNC_STAGES];

  logic [15:0] shreg_q, shreg_d;
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic [3:0]  faddr_q, faddr_d;
  logic [7:0]  fdata_q, fdata_d;
  logic        wr_en;
  logic        unused_ok;

  assign unused_ok = sck_s ^ sck_fall;

  always_comb begin
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    faddr_d  = faddr_q;
    fdata_d  = fdata_q;
    if (load_rise) begin
      // LOAD rise wins over a coincident SCK rise: latch the pre-edge shreg.
      faddr_d  = shreg_q[11:8];
      fdata_d  = shreg_q[7:0];
      bitcnt_d = '0;
    end else if (load_fall) begin
      bitcnt_d = '0;
    end else if (sck_rise && !load_s) begin
      shreg_d = {shreg_q[14:0], din_s};
      if (bitcnt_q != BITCNT_MAX) bitcnt_d = bitcnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q  <= '0;
      bitcnt_q <= '0;
      faddr_q  <= '0;
      fdata_q  <= '0;
    end else begin
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      faddr_q  <= faddr_d;
      fdata_q  <= fdata_d;
    end
  end

  assign frame_valid = load_rise;
  assign frame_addr  = load_rise ? shreg_q[11:8] : faddr_q;
  assign frame_data  = load_rise ? shreg_q[7:0]  : fdata_q;
  assign frame_err   = load_rise && (bitcnt_q != FRAME_BITS_C);
  assign wr_en       = load_rise && (bitcnt_q >= FRAME_BITS_C);

  logic [7:0][7:0] digit_q;
  logic [7:0]      decode_q;
  logic [3:0]      intensity_q;
  logic [2:0]      scanlim_q;
  logic            shutdown_q;
  logic            test_q;
  logic [3:0]      wa;
  logic [7:0]      wd;

  assign wa = shreg_q[11:8];
  assign wd = shreg_q[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q     <= '0;
      decode_q    <= '0;
      intensity_q <= '0;
      scanlim_q   <= '0;
      shutdown_q  <= 1'b0;
      test_q      <= 1'b0;
    end else if (wr_en) begin
      if (is_digit(wa)) digit_q[3'(wa - ADDR_DIGIT0)] <= wd;
      case (wa)
        ADDR_DECODE:    decode_q    <= wd;
        ADDR_INTENSITY: intensity_q <= wd[3:0];
        ADDR_SCANLIM:   scanlim_q   <= wd[2:0];
        ADDR_SHUTDOWN:  shutdown_q  <= wd[0];
        ADDR_TEST:      test_q      <= wd[0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    if (is_digit(rd_addr)) rd_data = digit_q[3'(rd_addr - ADDR_DIGIT0)];
    case (rd_addr)
      ADDR_DECODE:    rd_data = decode_q;
      ADDR_INTENSITY: rd_data = {4'b0, intensity_q};
      ADDR_SCANLIM:   rd_data = {5'b0, scanlim_q};
      ADDR_SHUTDOWN:  rd_data = {7'b0, shutdown_q};
      ADDR_TEST:      rd_data = {7'b0, test_q};
      default: ;
    endcase
  end

  assign shutdown_n   = shutdown_q;
  assign display_test = test_q;
  assign intensity    = intensity_q;
  assign scan_limit   = scanlim_q;
  assign decode_mode  = decode_q;
endmodule
